chip8_fetch: RTL and testbench
==============================

Name: chip8_fetch

Overview:
- Instruction fetch stage sitting directly upstream of the 4 KiB CHIP-8 byte memory.
- Owns the program counter and reads two consecutive bytes (big-endian) through the memory's single synchronous port. Presents the 16-bit opcode to the execute stage over a valid/ready handshake.
- Also arbitrates the shared memory port. Execute-stage data accesses (Fx55/Fx65, Dxyn sprite reads, Fx33 stores) take priority over fetch.

Parameters:
- RESET_PC, 12'h200, PC value after reset.
- ADDR_W, 12, memory address width; all PC arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_address  out  ADDR_W  to memory address.
- mem_set  out  1  to memory write enable.
- mem_data_in  out  8  to memory write data.
- mem_data_out  in  8  from memory; registered read data, valid the cycle after the address is presented.
- op  out  16  opcode, {byte[pc], byte[pc+1]}.
- op_pc  out  ADDR_W  address of the opcode's high byte.
- op_valid  out  1  opcode valid.
- op_ready  in  1  execute accepts opcode.
- pc_load  in  1  redirect the PC (jump, call, return, skip).
- pc_load_addr  in  ADDR_W  redirect target.
- ex_req  in  1  execute-stage memory access, granted the same cycle.
- ex_we  in  1  execute access is a write.
- ex_addr  in  ADDR_W  execute access address.
- ex_wdata  in  8  execute write data.
- ex_rdata  out  8  equals mem_data_out (pass-through).
- ex_rvalid  out  1  registered; high the cycle after a granted ex read.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=S_HI.
  - op=0, op_pc=0, op_valid=0, ex_rvalid=0.
  - Fetch restarts from S_HI when rst_n deasserts; reset mid-fetch discards partial bytes.
- Port mux (combinational):
  - If ex_req=1: mem_address=ex_addr, mem_set=ex_we, mem_data_in=ex_wdata.
  - Else: mem_set=0, mem_data_in=0, mem_address per state below.
  - ex_rvalid <= ex_req & ~ex_we on every clock.
- State S_HI: mem_address=pc. Next state is S_LO if ex_req=0, else stay in S_HI.
- State S_LO: mem_address=pc+1 (wraps 0xFFF->0x000).
  - If ex_req=0: hi <= mem_data_out, next S_CAP.
  - If ex_req=1: no capture, next S_HI (restart).
- State S_CAP:
  - op <= {hi, mem_data_out}, op_pc <= pc, op_valid <= 1, next S_VALID.
  - Completes even if ex_req=1 this cycle, because the captured byte was addressed in the previous cycle.
  - Latency: opcode valid 3 cycles after entering S_HI with no contention.
- State S_VALID: op, op_pc and op_valid are held stable. ex_req does not disturb them.
  - op_valid & op_ready: op_valid <= 0, pc <= pc+2, next S_HI.
  - Otherwise stay in S_VALID.
- Redirect (pc_load=1) in any state:
  - pc <= pc_load_addr, op_valid <= 0, next S_HI, and any in-flight capture is dropped.
  - pc_load overrides a same-cycle handshake, i.e. no +2 is applied.
  - A same-cycle ex_req is still serviced.
- The pc_load with handshake rule lets execute retire and redirect together; skips are pc_load(op_pc+4).
- Odd PC is legal; op_pc+1 and pc+2 wrap modulo 4096.
- No opcode is ever presented from bytes read under two different pc values.

Test Plan:
- Reset, then memory[0x200]=0x12, memory[0x201]=0x34, op_ready=1 -> op_valid rises on cycle 3 with op=0x1234, op_pc=0x200; next fetch is at 0x202.
- op_ready=0 for 5 cycles with op_valid=1 -> op and op_pc stable, no memory address change beyond pc; op_ready=1 -> pc advances exactly once.
- ex_req read of 0x050 asserted in S_LO -> ex_rvalid=1 next cycle with ex_rdata=0xF0 (font byte); fetch restarts at S_HI and the final op is correct and uncorrupted.
- ex_req write 0xAB to 0x300 while op_valid -> memory[0x300]=0xAB, op unchanged; a later fetch at 0x300 returns 0xAB in the high byte.
- pc_load=1 with pc_load_addr=0x456 in the same cycle as an accepted handshake -> next op_pc=0x456, not pc+2; pc_load during S_LO -> partial byte discarded.
- pc_load_addr=0xFFF, memory[0xFFF]=0xAA, memory[0x000]=0xBB -> op=0xAABB; after accept, pc=0x001. rst_n pulsed mid-S_LO -> op_valid=0 immediately, refetch from 0x200.

Source files
------------

// File: rtl/chip8_fetch.sv
// -----------------------------------------------------------------------------
// chip8_fetch
//
// Instruction fetch stage for the CHIP-8 core. It owns the program counter and
// reads each opcode as two big-endian bytes through the single synchronous port
// of the 4 KiB byte memory. The opcode is handed to the execute stage over a
// valid/ready handshake. The same memory port is shared with the execute stage,
// and execute accesses always win the port.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   mem_address       memory address (execute address when ex_req, else fetch)
//   mem_set           memory write enable (execute writes only)
//   mem_data_in       memory write data
//   mem_data_out      registered memory read data (one cycle after address)
//   op, op_pc         opcode {byte[pc], byte[pc+1]} and its high-byte address
//   op_valid          opcode valid; held stable until accepted or redirected
//   op_ready          execute accepts the opcode
//   pc_load           redirect the PC to pc_load_addr (wins over a handshake)
//   ex_req, ex_we     execute-stage memory access request / write select
//   ex_addr, ex_wdata execute-stage address / write data
//   ex_rdata          read data for execute (pass-through of mem_data_out)
//   ex_rvalid         registered; high the cycle after a granted execute read
// -----------------------------------------------------------------------------
module chip8_fetch #(
    parameter int                 ADDR_W   = 12,
    parameter logic [ADDR_W-1:0]  RESET_PC = 12'h200
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_set,
    output logic [7:0]        mem_data_in,
    input  logic [7:0]        mem_data_out,
    output logic [15:0]       op,
    output logic [ADDR_W-1:0] op_pc,
    output logic              op_valid,
    input  logic              op_ready,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_addr,
    input  logic              ex_req,
    input  logic              ex_we,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [7:0]        ex_wdata,
    output logic [7:0]        ex_rdata,
    output logic              ex_rvalid
);

    typedef enum logic [1:0] {
        S_HI    = 2'd0,   // high byte address on the port
        S_LO    = 2'd1,   // low byte address on the port, high byte returning
        S_CAP   = 2'd2,   // low byte returning, opcode assembled
        S_VALID = 2'd3    // opcode presented, waiting for acceptance
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(2'd1);
    localparam logic [ADDR_W-1:0] PC_TWO = ADDR_W'(2'd2);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   pc_r;
    logic [ADDR_W-1:0]   pc_nxt_s;
    logic [7:0]          hi_r;
    logic [7:0]          hi_nxt_s;
    logic [15:0]         op_r;
    logic [15:0]         op_nxt_s;
    logic [ADDR_W-1:0]   op_pc_r;
    logic [ADDR_W-1:0]   op_pc_nxt_s;
    logic                op_valid_r;
    logic                op_valid_nxt_s;
    logic                ex_rvalid_r;
    logic [ADDR_W-1:0]   fetch_addr_s;

    // Fetch sequencer: next state, PC update, byte capture and fetch address.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        hi_nxt_s       = hi_r;
        op_nxt_s       = op_r;
        op_pc_nxt_s    = op_pc_r;
        op_valid_nxt_s = op_valid_r;
        fetch_addr_s   = pc_r;

        case (state_r)
            S_HI: begin
                fetch_addr_s = pc_r;
                // An execute access steals the port; re-issue the high byte.
                if (ex_req) begin
                    state_nxt_s = S_HI;
                end else begin
                    state_nxt_s = S_LO;
                end
            end
            S_LO: begin
                fetch_addr_s = pc_r + PC_ONE;
                // Data now on mem_data_out is byte[pc]. If the port is stolen
                // the low byte read is lost, so the whole fetch restarts.
                if (ex_req) begin
                    state_nxt_s = S_HI;
                end else begin
                    hi_nxt_s    = mem_data_out;
                    state_nxt_s = S_CAP;
                end
            end
            S_CAP: begin
                // The low byte was addressed last cycle, so a competing
                // execute access this cycle cannot corrupt it.
                fetch_addr_s   = pc_r;
                op_nxt_s       = {hi_r, mem_data_out};
                op_pc_nxt_s    = pc_r;
                op_valid_nxt_s = 1'b1;
                state_nxt_s    = S_VALID;
            end
            S_VALID: begin
                fetch_addr_s = pc_r;
                if (op_valid_r && op_ready) begin
                    op_valid_nxt_s = 1'b0;
                    pc_nxt_s       = pc_r + PC_TWO;
                    state_nxt_s    = S_HI;
                end else begin
                    state_nxt_s = S_VALID;
                end
            end
            default: begin
                fetch_addr_s = pc_r;
                state_nxt_s  = S_HI;
            end
        endcase

        // A redirect wins over everything above, including a same-cycle
        // handshake (no +2) and an in-flight capture (opcode left untouched).
        if (pc_load) begin
            pc_nxt_s       = pc_load_addr;
            op_nxt_s       = op_r;
            op_pc_nxt_s    = op_pc_r;
            op_valid_nxt_s = 1'b0;
            state_nxt_s    = S_HI;
        end else begin
            pc_nxt_s = pc_nxt_s;
        end
    end

    // Memory port arbitration: execute accesses take the port unconditionally.
    always_comb begin
        if (ex_req) begin
            mem_address = ex_addr;
            mem_set     = ex_we;
            mem_data_in = ex_wdata;
        end else begin
            mem_address = fetch_addr_s;
            mem_set     = 1'b0;
            mem_data_in = 8'h00;
        end
    end

    // State, PC, opcode and execute read-valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_HI;
            pc_r        <= RESET_PC;
            hi_r        <= 8'h00;
            op_r        <= 16'h0000;
            op_pc_r     <= '0;
            op_valid_r  <= 1'b0;
            ex_rvalid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            hi_r        <= hi_nxt_s;
            op_r        <= op_nxt_s;
            op_pc_r     <= op_pc_nxt_s;
            op_valid_r  <= op_valid_nxt_s;
            ex_rvalid_r <= ex_req & ~ex_we;
        end
    end

    assign op        = op_r;
    assign op_pc     = op_pc_r;
    assign op_valid  = op_valid_r;
    assign ex_rvalid = ex_rvalid_r;
    assign ex_rdata  = mem_data_out;

endmodule

// File: tb/tb_chip8_fetch.sv
// -----------------------------------------------------------------------------
// tb_chip8_fetch
//
// Directed bench for chip8_fetch with a behavioural 4 KiB synchronous memory.
// Inputs are driven 1 ns after the rising edge and outputs sampled there too.
// -----------------------------------------------------------------------------
module tb_chip8_fetch;

    logic        clk;
    logic        rst_n;
    logic [11:0] mem_address;
    logic        mem_set;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out;
    logic [15:0] op;
    logic [11:0] op_pc;
    logic        op_valid;
    logic        op_ready;
    logic        pc_load;
    logic [11:0] pc_load_addr;
    logic        ex_req;
    logic        ex_we;
    logic [11:0] ex_addr;
    logic [7:0]  ex_wdata;
    logic [7:0]  ex_rdata;
    logic        ex_rvalid;

    logic [7:0]  mem [0:4095];

    int vec_cnt = 0;
    int err_cnt = 0;

    chip8_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_address  (mem_address),
        .mem_set      (mem_set),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .op           (op),
        .op_pc        (op_pc),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .ex_req       (ex_req),
        .ex_we        (ex_we),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .ex_rdata     (ex_rdata),
        .ex_rvalid    (ex_rvalid)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous byte memory: registered read, write on mem_set.
    always @(posedge clk) begin
        if (mem_set) mem[mem_address] <= mem_data_in;
        mem_data_out <= mem[mem_address];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        op_ready     = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = 12'h000;
        ex_req       = 1'b0;
        ex_we        = 1'b0;
        ex_addr      = 12'h000;
        ex_wdata     = 8'h00;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h000] = 8'hBB;
        mem[12'h050] = 8'hF0;
        mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
        mem[12'h202] = 8'h56; mem[12'h203] = 8'h78;
        mem[12'h204] = 8'h9E; mem[12'h205] = 8'h01;
        mem[12'h301] = 8'h11;
        mem[12'h456] = 8'h9A; mem[12'h457] = 8'hBC;
        mem[12'hFFF] = 8'hAA;

        // Reset state
        repeat (2) tick();
        check("rst_op_valid", 32'(op_valid), 32'h0);
        check("rst_op", 32'(op), 32'h0);
        check("rst_op_pc", 32'(op_pc), 32'h0);
        check("rst_ex_rvalid", 32'(ex_rvalid), 32'h0);
        check("rst_addr", 32'(mem_address), 32'h200);
        check("rst_mem_set", 32'(mem_set), 32'h0);
        rst_n = 1'b1;

        // First fetch: valid on the third edge
        tick(); check("f1_lo_addr", 32'(mem_address), 32'h201);
                check("f1_lo_valid", 32'(op_valid), 32'h0);
        tick(); check("f1_cap_valid", 32'(op_valid), 32'h0);
        tick(); check("f1_valid", 32'(op_valid), 32'h1);
                check("f1_op", 32'(op), 32'h1234);
                check("f1_op_pc", 32'(op_pc), 32'h200);

        // Back-pressure: everything held
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_op", 32'(op), 32'h1234);
            check("hold_op_pc", 32'(op_pc), 32'h200);
            check("hold_valid", 32'(op_valid), 32'h1);
            check("hold_addr", 32'(mem_address), 32'h200);
        end
        op_ready = 1'b1;
        tick(); op_ready = 1'b0;
        check("acc_valid", 32'(op_valid), 32'h0);
        check("acc_addr", 32'(mem_address), 32'h202);
        repeat (3) tick();
        check("f2_op", 32'(op), 32'h5678);
        check("f2_op_pc", 32'(op_pc), 32'h202);

        // Execute read of a font byte during S_LO
        op_ready = 1'b1;
        tick(); op_ready = 1'b0;
        check("f3_hi_addr", 32'(mem_address), 32'h204);
        tick(); check("f3_lo_addr", 32'(mem_address), 32'h205);
        ex_req = 1'b1; ex_we = 1'b0; ex_addr = 12'h050;
        #1 check("exr_addr", 32'(mem_address), 32'h050);
        tick(); ex_req = 1'b0;
        #1;
        check("exr_rvalid", 32'(ex_rvalid), 32'h1);
        check("exr_rdata", 32'(ex_rdata), 32'hF0);
        check("exr_restart", 32'(mem_address), 32'h204);
        tick(); check("exr_rvalid_low", 32'(ex_rvalid), 32'h0);
        repeat (2) tick();
        check("f3_op", 32'(op), 32'h9E01);
        check("f3_op_pc", 32'(op_pc), 32'h204);
        check("f3_valid", 32'(op_valid), 32'h1);

        // Execute write while an opcode is presented
        ex_req = 1'b1; ex_we = 1'b1; ex_addr = 12'h300; ex_wdata = 8'hAB;
        #1;
        check("exw_set", 32'(mem_set), 32'h1);
        check("exw_addr", 32'(mem_address), 32'h300);
        check("exw_data", 32'(mem_data_in), 32'hAB);
        tick(); ex_req = 1'b0; ex_we = 1'b0;
        check("exw_rvalid", 32'(ex_rvalid), 32'h0);
        check("exw_mem", 32'(mem[12'h300]), 32'hAB);
        check("exw_op", 32'(op), 32'h9E01);
        check("exw_valid", 32'(op_valid), 32'h1);

        // Redirect with a same-cycle handshake: no +2
        op_ready = 1'b1; pc_load = 1'b1; pc_load_addr = 12'h456;
        tick(); op_ready = 1'b0; pc_load = 1'b0;
        #1;
        check("rd_valid", 32'(op_valid), 32'h0);
        check("rd_addr", 32'(mem_address), 32'h456);
        repeat (3) tick();
        check("rd_op", 32'(op), 32'h9ABC);
        check("rd_op_pc", 32'(op_pc), 32'h456);

        // Fetch of the freshly written byte
        pc_load = 1'b1; pc_load_addr = 12'h300;
        tick(); pc_load = 1'b0;
        repeat (3) tick();
        check("w_op", 32'(op), 32'hAB11);
        check("w_op_pc", 32'(op_pc), 32'h300);

        // Redirect during S_LO drops the partial byte
        pc_load = 1'b1; pc_load_addr = 12'h300;
        tick(); pc_load = 1'b0;
        tick();
        pc_load = 1'b1; pc_load_addr = 12'h202;
        tick(); pc_load = 1'b0;
        #1;
        check("lo_rd_addr", 32'(mem_address), 32'h202);
        check("lo_rd_valid", 32'(op_valid), 32'h0);
        repeat (3) tick();
        check("lo_rd_op", 32'(op), 32'h5678);
        check("lo_rd_op_pc", 32'(op_pc), 32'h202);

        // Address wrap at the top of memory
        pc_load = 1'b1; pc_load_addr = 12'hFFF;
        tick(); pc_load = 1'b0;
        #1 check("wr_hi_addr", 32'(mem_address), 32'hFFF);
        tick(); check("wr_lo_addr", 32'(mem_address), 32'h000);
        repeat (2) tick();
        check("wr_op", 32'(op), 32'hAABB);
        check("wr_op_pc", 32'(op_pc), 32'hFFF);
        op_ready = 1'b1;
        tick(); op_ready = 1'b0;
        #1;
        check("wr_next_pc", 32'(mem_address), 32'h001);
        tick(); check("wr_next_lo", 32'(mem_address), 32'h002);

        // Asynchronous reset in the middle of S_LO
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(op_valid), 32'h0);
        check("arst_op", 32'(op), 32'h0);
        check("arst_op_pc", 32'(op_pc), 32'h0);
        check("arst_addr", 32'(mem_address), 32'h200);
        @(posedge clk); #1 rst_n = 1'b1;
        tick(); check("re_lo_addr", 32'(mem_address), 32'h201);
        tick();
        // Execute read during S_CAP must not spoil the capture
        ex_req = 1'b1; ex_we = 1'b0; ex_addr = 12'h050;
        tick(); ex_req = 1'b0;
        #1;
        check("re_op", 32'(op), 32'h1234);
        check("re_op_pc", 32'(op_pc), 32'h200);
        check("re_valid", 32'(op_valid), 32'h1);
        check("re_rvalid", 32'(ex_rvalid), 32'h1);
        check("re_rdata", 32'(ex_rdata), 32'hF0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
